// File: rtl/risc_pkg.sv
// Shared constants and state encoding for the RISC fetch stage.
package risc_pkg;

  localparam int          ADDR_W    = 32;
  localparam int          INSTR_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DROP,
    FAULT
  } fetch_state_t;

endpackage

// File: rtl/risc_fetch_stage_if_id_pipe_reg.sv
// IF/ID pipeline register: single-entry valid/ready slot with flush.
// Carries a misalign flag when RISC_FETCH_MISALIGN_TRAP_EN is defined.
module if_id_pipe_reg #(
  parameter int ADDR_W  = risc_pkg::ADDR_W,
  parameter int INSTR_W = risc_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               load_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [INSTR_W-1:0] instr_i,
`ifdef RISC_FETCH_MISALIGN_TRAP_EN
  input  logic               misalign_i,
  output logic               misalign_o,
`endif
  input  logic               ready_i,
  output logic               valid_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INSTR_W-1:0] instr_o
);

  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  // Flush beats a same-cycle load and a same-cycle consume.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

`ifdef RISC_FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = misalign_q;
    if (flush_i) begin
      misalign_d = 1'b0;
    end else if (load_i) begin
      misalign_d = misalign_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_o = misalign_q;
`endif

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/risc_fetch_stage.sv
// Instruction-fetch stage: owns the PC, one outstanding imem request, feeds IF/ID.
// Define RISC_FETCH_MISALIGN_TRAP_EN to trap misaligned redirects instead of aligning them.
module risc_fetch_stage #(
  parameter int                 ADDR_W   = risc_pkg::ADDR_W,
  parameter int                 INSTR_W  = risc_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 PC_INC   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_id_valid,
  input  logic               if_id_ready,
  output logic [ADDR_W-1:0]  if_id_pc,
`ifdef RISC_FETCH_MISALIGN_TRAP_EN
  output logic               if_id_misalign,
`endif
  output logic [INSTR_W-1:0] if_id_instr
);

  import risc_pkg::*;

  fetch_state_t       state_q;
  logic [ADDR_W-1:0]  pc_q, req_pc_q;
  logic [ADDR_W-1:0]  redirect_pc_eff;
  logic               slot_free, pc_misaligned, trap_take, rsp_take, ifid_load;
  logic [ADDR_W-1:0]  ifid_pc_in;
  logic [INSTR_W-1:0] ifid_instr_in;

  assign slot_free = !if_id_valid || if_id_ready;

`ifdef RISC_FETCH_MISALIGN_TRAP_EN
  assign redirect_pc_eff = redirect_pc;
  assign pc_misaligned   = |pc_q[1:0];
`else
  assign redirect_pc_eff = redirect_pc & ~ADDR_W'(3);
  assign pc_misaligned   = 1'b0;
`endif

  // A misaligned PC never reaches memory; it turns into a NOP trap entry instead.
  always_comb begin
    imem_req_valid = rst_n && (state_q == FETCH) && !pc_misaligned &&
                     slot_free && !redirect_valid;
    trap_take      = (state_q == FETCH) && pc_misaligned && slot_free && !redirect_valid;
    rsp_take       = (state_q == WAIT) && imem_rsp_valid && !redirect_valid;
    ifid_load      = rsp_take || trap_take;
    ifid_pc_in     = trap_take ? pc_q : req_pc_q;
    ifid_instr_in  = trap_take ? INSTR_W'(NOP_INSTR) : imem_rsp_data;
  end

  assign imem_req_addr = pc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc_eff;
      // An un-arrived response must still be drained before fetching again.
      case (state_q)
        WAIT, DROP: state_q <= imem_rsp_valid ? FETCH : DROP;
        default:    state_q <= FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (trap_take) begin
            state_q <= FAULT;
          end else if (imem_req_valid && imem_req_ready) begin
            req_pc_q <= pc_q;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            pc_q    <= req_pc_q + ADDR_W'(PC_INC);
            state_q <= FETCH;
          end
        end
        DROP: begin
          if (imem_rsp_valid) begin
            state_q <= FETCH;
          end
        end
        FAULT:   state_q <= FAULT;
        default: state_q <= FETCH;
      endcase
    end
  end

  if_id_pipe_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (redirect_valid),
    .load_i     (ifid_load),
    .pc_i       (ifid_pc_in),
    .instr_i    (ifid_instr_in),
`ifdef RISC_FETCH_MISALIGN_TRAP_EN
    .misalign_i (trap_take),
    .misalign_o (if_id_misalign),
`endif
    .ready_i    (if_id_ready),
    .valid_o    (if_id_valid),
    .pc_o       (if_id_pc),
    .instr_o    (if_id_instr)
  );

endmodule

// File: tb/tb_risc_fetch_stage.sv
// Self-checking bench for risc_fetch_stage: directed scenarios then random traffic
// against a transaction-level model of the fetch stream.
module tb_risc_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid, if_id_ready;
  logic [31:0] if_id_pc, if_id_instr;
`ifdef RISC_FETCH_MISALIGN_TRAP_EN
  logic        if_id_misalign;
`endif

  always #5 clk = ~clk;

  risc_fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_ready    (if_id_ready),
    .if_id_pc       (if_id_pc),
`ifdef RISC_FETCH_MISALIGN_TRAP_EN
    .if_id_misalign (if_id_misalign),
`endif
    .if_id_instr    (if_id_instr)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } item_t;

  item_t       exp_q[$];          // what decode should see, in order
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        pend_valid = 1'b0; // memory holds an accepted request
  logic [31:0] pend_addr = '0;
  int          pend_wait = 0;
  logic        live = 1'b0;       // outstanding response is still wanted
  logic [31:0] exp_pc = 32'h0;
  logic        trap_pend = 1'b0;
  logic        fault = 1'b0;
  int          mem_delay = 0;
  logic [31:0] req_log_addr[$];
  int          req_log_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_00FF;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic rdy_d, input logic rdy_m, input logic redir,
                      input logic [31:0] rpc);
    logic        exp_req, fire, rsp_now, consume, was_pend;
    logic [31:0] rsp_addr, rsp_data;
    item_t       it;
    @(negedge clk);
    cyc++;
    rsp_now        = pend_valid && (pend_wait == 0);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_word(pend_addr) : $urandom;
    if_id_ready    = rdy_d;
    imem_req_ready = rdy_m;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
    check("if_id_valid", if_id_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("if_id_pc", if_id_pc, exp_q[0].pc);
      check("if_id_instr", if_id_instr, exp_q[0].instr);
`ifdef RISC_FETCH_MISALIGN_TRAP_EN
      check("if_id_misalign", if_id_misalign, exp_q[0].mis);
`endif
    end
    exp_req = !pend_valid && !redir && !trap_pend && !fault && (exp_q.size() == 0 || rdy_d);
    check("req_valid", imem_req_valid, exp_req);
    if (imem_req_valid) check("req_addr", imem_req_addr, exp_pc);

    fire     = imem_req_valid && rdy_m;
    consume  = (exp_q.size() != 0) && rdy_d;
    rsp_addr = pend_addr;
    rsp_data = imem_rsp_data;
    was_pend = pend_valid;
    if (rsp_now) pend_valid = 1'b0;
    else if (pend_valid) pend_wait--;
    if (redir) begin
      exp_q.delete();
      live  = 1'b0;
      fault = 1'b0;
`ifdef RISC_FETCH_MISALIGN_TRAP_EN
      exp_pc    = rpc;
      trap_pend = (rpc[1:0] != 2'b00);
`else
      exp_pc = rpc & ~32'h3;
`endif
    end else begin
      if (consume) begin
        $display("xfer cycle=%0d pc=%h instr=%h", cyc, exp_q[0].pc, exp_q[0].instr);
        void'(exp_q.pop_front());
      end
      if (rsp_now && live) begin
        it.pc = rsp_addr; it.instr = rsp_data; it.mis = 1'b0;
        exp_q.push_back(it);
        exp_pc = rsp_addr + 32'd4;
      end
      if (trap_pend && !was_pend && exp_q.size() == 0) begin
        it.pc = exp_pc; it.instr = 32'h0000_0013; it.mis = 1'b1;
        exp_q.push_back(it);
        trap_pend = 1'b0;
        fault     = 1'b1;
      end
    end
    if (fire) begin
      pend_valid = 1'b1;
      pend_addr  = imem_req_addr;
      pend_wait  = mem_delay;
      live       = 1'b1;
      req_log_addr.push_back(imem_req_addr);
      req_log_cyc.push_back(cyc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n0, rcyc;
    logic [31:0] rpc_r;
    rst_n = 1'b0; if_id_ready = 1'b1; imem_req_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_if_id_valid", if_id_valid, 0);
    check("rst_if_id_pc", if_id_pc, 32'h0);
    check("rst_if_id_instr", if_id_instr, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Zero-wait memory: requests at 0,4,8, two cycles apart.
    mem_delay = 0;
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("t1_nreq", req_log_addr.size(), 3);
    for (int i = 0; i < 3 && i < req_log_addr.size(); i++)
      check($sformatf("t1_addr%0d", i), req_log_addr[i], 32'(i * 4));
    if (req_log_cyc.size() >= 3) begin
      check("t1_gap1", req_log_cyc[1] - req_log_cyc[0], 2);
      check("t1_gap2", req_log_cyc[2] - req_log_cyc[1], 2);
    end

    // Decode stalls with the slot full: no requests, outputs held.
    n0 = req_log_addr.size();
    repeat (5) step(1'b0, 1'b1, 1'b0, 32'h0);
    check("t2_hold_noreq", req_log_addr.size() - n0, 0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("t2_release_req", req_log_addr.size() - n0, 1);

    // Redirect during WAIT, late response is dropped.
    mem_delay = 3;
    for (int k = 0; k < 10 && !(pend_valid && pend_wait == 3); k++) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("t3_inflight", pend_valid, 1);
    n0 = req_log_addr.size();
    step(1'b1, 1'b1, 1'b1, 32'h100);
    mem_delay = 0;
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("t3_nreq", req_log_addr.size() > n0, 1);
    if (req_log_addr.size() > n0) check("t3_addr", req_log_addr[n0], 32'h100);

    // Redirect coincident with the response.
    mem_delay = 1;
    for (int k = 0; k < 10 && !(pend_valid && pend_wait == 0); k++) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("t4_rsp_due", pend_valid, 1);
    n0 = req_log_addr.size();
    step(1'b1, 1'b1, 1'b1, 32'h240);
    rcyc = cyc;
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("t4_nreq", req_log_addr.size() > n0, 1);
    if (req_log_addr.size() > n0) begin
      check("t4_addr", req_log_addr[n0], 32'h240);
      check("t4_latency", req_log_cyc[n0] - rcyc, 1);
    end

    // PC wrap at the top of the address space.
    mem_delay = 0;
    n0 = req_log_addr.size();
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("t5_nreq", req_log_addr.size() >= n0 + 2, 1);
    if (req_log_addr.size() >= n0 + 2) begin
      check("t5_addr0", req_log_addr[n0], 32'hFFFF_FFFC);
      check("t5_addr1", req_log_addr[n0 + 1], 32'h0);
    end

`ifdef RISC_FETCH_MISALIGN_TRAP_EN
    // Misaligned redirect traps with a NOP entry and stops fetching.
    n0 = req_log_addr.size();
    step(1'b0, 1'b1, 1'b1, 32'h102);
    repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0);
    check("t6_trap_valid", if_id_valid, 1);
    check("t6_trap_pc", if_id_pc, 32'h102);
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("t6_noreq", req_log_addr.size() - n0, 0);
    step(1'b1, 1'b1, 1'b1, 32'h200);
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("t6_nreq", req_log_addr.size() > n0, 1);
    if (req_log_addr.size() > n0) check("t6_addr", req_log_addr[n0], 32'h200);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      mem_delay = $urandom_range(0, 2);
      case ($urandom_range(0, 2))
        0:       rpc_r = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        default: rpc_r = $urandom & 32'h0000_FFFF;
      endcase
`ifdef RISC_FETCH_MISALIGN_TRAP_EN
      rpc_r = rpc_r & ~32'h3;
`endif
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 4, rpc_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
